// File: rtl/pwm_pkg.sv
// Shared widths, limits and FSM state encoding for the PWM sequence controller.
package pwm_pkg;

  localparam int PERIOD_W_DFLT = 16;
  localparam int DUTY_W_DFLT   = 8;
  localparam int REP_W_DFLT    = 8;
  localparam int DUTY_MAX      = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_seq_table.sv
// Profile table: one write port, one combinational read port, cleared by reset.
module pwm_seq_table
  import pwm_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = PERIOD_W_DFLT,
  parameter int DUTY_W   = DUTY_W_DFLT,
  parameter int REP_W    = REP_W_DFLT,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [PERIOD_W-1:0] wperiod,
  input  logic [DUTY_W-1:0]   wduty,
  input  logic [REP_W-1:0]    wreps,
  input  logic                wlast,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [PERIOD_W-1:0] rperiod,
  output logic [DUTY_W-1:0]   rduty,
  output logic [REP_W-1:0]    rreps,
  output logic                rlast
);

  logic [PERIOD_W-1:0] period_q [DEPTH];
  logic [DUTY_W-1:0]   duty_q   [DEPTH];
  logic [REP_W-1:0]    reps_q   [DEPTH];
  logic [DEPTH-1:0]    last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        reps_q[i]   <= '0;
      end
      last_q <= '0;
    end else if (we) begin
      period_q[waddr] <= wperiod;
      duty_q[waddr]   <= wduty;
      reps_q[waddr]   <= wreps;
      last_q[waddr]   <= wlast;
    end
  end

  assign rperiod = period_q[raddr];
  assign rduty   = duty_q[raddr];
  assign rreps   = reps_q[raddr];
  assign rlast   = last_q[raddr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Steps a PWM generator through a table of {period, duty, repeats} profiles,
// optionally looping, with a sticky error flag for bad entries and busy writes.
module pwm_seq_ctrl
  import pwm_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = PERIOD_W_DFLT,
  parameter int DUTY_W   = DUTY_W_DFLT,
  parameter int REP_W    = REP_W_DFLT,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  input  logic [REP_W-1:0]    cfg_reps,
  input  logic                cfg_last,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                cyc_done,
  output logic [PERIOD_W-1:0] pwm_period,
  output logic [DUTY_W-1:0]   pwm_duty,
  output logic                pwm_en,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   cur_idx,
  output logic                err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                en_q, en_d;
  logic                err_q, err_d;
  logic                adv;

  logic [PERIOD_W-1:0] rd_period;
  logic [DUTY_W-1:0]   rd_duty;
  logic [REP_W-1:0]    rd_reps;
  logic                rd_last;

  pwm_seq_table #(
    .DEPTH(DEPTH), .PERIOD_W(PERIOD_W), .DUTY_W(DUTY_W), .REP_W(REP_W), .ADDR_W(ADDR_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we && (state_q == ST_IDLE)),
    .waddr  (cfg_addr),
    .wperiod(cfg_period),
    .wduty  (cfg_duty),
    .wreps  (cfg_reps),
    .wlast  (cfg_last),
    .raddr  (idx_q),
    .rperiod(rd_period),
    .rduty  (rd_duty),
    .rreps  (rd_reps),
    .rlast  (rd_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rep_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      en_q     <= en_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    period_d = period_q;
    duty_d   = duty_q;
    en_d     = en_q;
    err_d    = err_q;
    adv      = 1'b0;

    if (cfg_we && (state_q != ST_IDLE)) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (rd_period == '0) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          period_d = rd_period;
          if (rd_duty > DUTY_W'(DUTY_MAX)) begin
            duty_d = DUTY_W'(DUTY_MAX);
            err_d  = 1'b1;
          end else begin
            duty_d = rd_duty;
          end
          rep_d   = (rd_reps == '0) ? REP_W'(1) : rd_reps;
          en_d    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cyc_done) begin
          rep_d = rep_q - REP_W'(1);
          if (rep_q == REP_W'(1)) adv = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // pwm_en is only dropped when the sequence truly ends, so LOAD between entries keeps it high
    if (adv) begin
      if (rd_last || (idx_q == ADDR_W'(DEPTH - 1))) begin
        if (loop_en) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_FINISH;
        end
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = ST_LOAD;
      end
    end

    if (stop) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_FINISH);
    pwm_period = period_q;
    pwm_duty   = duty_q;
    pwm_en     = en_q;
    cur_idx    = idx_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl; inputs change and outputs are sampled 1ns after each rising edge.
module tb_pwm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_duty;
  logic [7:0]  cfg_reps;
  logic        cfg_last;
  logic        start, stop, loop_en, cyc_done;
  logic [15:0] pwm_period;
  logic [7:0]  pwm_duty;
  logic        pwm_en, busy, done, err;
  logic [2:0]  cur_idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  // flags = {busy, done, pwm_en, err, cur_idx}
  wire [6:0]  flags = {busy, done, pwm_en, err, cur_idx};
  wire [23:0] pwm   = {pwm_period, pwm_duty};

  always #5 clk = ~clk;

  pwm_seq_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_reps(cfg_reps), .cfg_last(cfg_last), .start(start), .stop(stop),
    .loop_en(loop_en), .cyc_done(cyc_done), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
    .pwm_en(pwm_en), .busy(busy), .done(done), .cur_idx(cur_idx), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [15:0] p, input logic [7:0] d,
                             input logic [7:0] r, input logic l);
    cfg_we = 1'b1; cfg_addr = a; cfg_period = p; cfg_duty = d; cfg_reps = r; cfg_last = l;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cyc();
    cyc_done = 1'b1;
    step();
    cyc_done = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic [6:0] exp);
    vec_cnt++;
    if (flags !== exp) begin
      err_cnt++;
      $display("FAIL %s flags{busy,done,en,err,idx} got %b exp %b", name, flags, exp);
    end
  endtask

  task automatic chk_pwm(input string name, input logic [15:0] p, input logic [7:0] d);
    vec_cnt++;
    if (pwm !== {p, d}) begin
      err_cnt++;
      $display("FAIL %s pwm period/duty got %0d/%0d exp %0d/%0d", name, pwm_period, pwm_duty, p, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_period = '0; cfg_duty = '0; cfg_reps = '0;
    cfg_last = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; cyc_done = 1'b0;
    step(); step();
    chk_flags("reset_flags", 7'b0000_000);
    chk_pwm("reset_pwm", 16'd0, 8'd0);
    rst = 1'b1;
    cyc();
    chk_flags("idle_cyc_ignored", 7'b0000_000);
  endtask

  task automatic test_basic();
    write_entry(3'd0, 16'd1000, 8'd50, 8'd2, 1'b0);
    write_entry(3'd1, 16'd2000, 8'd25, 8'd1, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    chk_flags("basic_load0", 7'b1000_000);
    cyc();
    chk_flags("basic_run0", 7'b1010_000);
    chk_pwm("basic_pwm0", 16'd1000, 8'd50);
    cyc();
    chk_flags("basic_rep1", 7'b1010_000);
    cyc();
    chk_flags("basic_load1_en_held", 7'b1010_001);
    step();
    chk_pwm("basic_pwm1", 16'd2000, 8'd25);
    cyc();
    chk_flags("basic_finish", 7'b1100_001);
    step();
    chk_flags("basic_idle", 7'b0000_001);
  endtask

  task automatic test_loop();
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk_flags("loop_load0", 7'b1000_000);
    step();
    for (int p = 0; p < 3; p++) begin
      cyc(); cyc();
      chk_flags($sformatf("loop%0d_idx1", p), 7'b1010_001);
      step();
      chk_pwm($sformatf("loop%0d_pwm1", p), 16'd2000, 8'd25);
      cyc();
      chk_flags($sformatf("loop%0d_wrap", p), 7'b1010_000);
      step();
      chk_pwm($sformatf("loop%0d_pwm0", p), 16'd1000, 8'd50);
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk_flags("loop_stop", 7'b0000_000);
    step();
    chk_flags("loop_no_done", 7'b0000_000);
    loop_en = 1'b0;
  endtask

  task automatic test_clamp();
    write_entry(3'd0, 16'd300, 8'd150, 8'd0, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk_flags("clamp_run", 7'b1011_000);
    chk_pwm("clamp_pwm", 16'd300, 8'd100);
    cyc();
    chk_flags("clamp_one_rep", 7'b1101_000);
    step();
    chk_flags("clamp_err_sticky", 7'b0001_000);
  endtask

  task automatic test_skip();
    write_entry(3'd0, 16'd0, 8'd20, 8'd3, 1'b0);
    write_entry(3'd1, 16'd500, 8'd10, 8'd1, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    chk_flags("skip_start_clears_err", 7'b1000_000);
    step();
    chk_flags("skip_load1", 7'b1001_001);
    step();
    chk_flags("skip_run1", 7'b1011_001);
    chk_pwm("skip_pwm1", 16'd500, 8'd10);
    cyc();
    chk_flags("skip_finish", 7'b1101_001);
    step();
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk_flags("start_stop_idle", 7'b0001_001);
    step();
    chk_flags("start_stop_still_idle", 7'b0001_001);
  endtask

  task automatic test_reset_mid();
    write_entry(3'd0, 16'd1000, 8'd50, 8'd2, 1'b0);
    write_entry(3'd1, 16'd2000, 8'd25, 8'd1, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk_flags("mid_run0", 7'b1010_000);
    write_entry(3'd1, 16'd4000, 8'd75, 8'd1, 1'b1);
    chk_flags("busy_write_err", 7'b1011_000);
    cyc(); cyc();
    chk_flags("mid_load1", 7'b1011_001);
    step();
    chk_pwm("busy_write_ignored", 16'd2000, 8'd25);
    rst = 1'b0; step(); rst = 1'b1;
    chk_flags("mid_reset_flags", 7'b0000_000);
    chk_pwm("mid_reset_pwm", 16'd0, 8'd0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk_flags("cleared_skip_to_7", 7'b1001_111);
    step();
    chk_flags("cleared_finish", 7'b1101_111);
    chk_pwm("cleared_pwm", 16'd0, 8'd0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout vectors=%0d", vec_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_clamp();
    test_skip();
    test_start_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
